// File: rtl/inv_mix_columns_seq.sv
// ============================================================================
// inv_mix_columns_seq : iterative AES InvMixColumns, NUM_LANES columns/cycle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_mix_columns_seq #(
  parameter int NUM_LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4)) begin : g_bad_lanes
    $error("inv_mix_columns_seq: NUM_LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // A lane count of 4 truncates to 0, so the 2-bit counter simply stays at 0.
  localparam logic [1:0] LANE_STEP = 2'(NUM_LANES);

  state_e       state_q;
  logic [1:0]   col_q;
  logic [127:0] data_q;
  logic [127:0] data_d;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         last_grp;
  logic [31:0]  cols_cur [4];
  logic [31:0]  cols_d   [4];
  logic [1:0]   idx;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] b0, b1, b2, b3;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    b0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    b1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    b2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    b3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return {b0, b1, b2, b3};
  endfunction

  // Only the current column group is rewritten; the rest pass through.
  always_comb begin
    idx = 2'd0;
    for (int c = 0; c < 4; c++) begin
      cols_cur[c] = data_q[127-32*c -: 32];
      cols_d[c]   = cols_cur[c];
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      idx         = col_q + 2'(l);
      cols_d[idx] = inv_mix_col(cols_cur[idx]);
    end
    data_d = {cols_d[0], cols_d[1], cols_d[2], cols_d[3]};
  end

  assign last_grp = ((3'(col_q) + 3'(NUM_LANES)) == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_state;
            col_q      <= 2'd0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          data_q <= data_d;
          col_q  <= col_q + LANE_STEP;
          if (last_grp) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = data_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
// ============================================================================
// tb_inv_mix_columns_seq : randomized bench for inv_mix_columns_seq (1/2/4 lanes)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   iv;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [2:0]   ordy;
  logic [127:0] ist [3];
  logic [127:0] ost [3];

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.NUM_LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]));
  inv_mix_columns_seq #(.NUM_LANES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]));
  inv_mix_columns_seq #(.NUM_LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]));

  // ---------------- reference model: generic GF(2^8) matrix product ---------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mat_apply(input logic [127:0] s,
                                             input logic [31:0] row0);
    logic [7:0] k [4];
    logic [7:0] a, acc;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) k[i] = row0[31-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          a   = s[127-8*(4*c+j) -: 8];
          acc = acc ^ gmul(k[(j - rr + 4) % 4], a);
        end
        r[127-8*(4*c+rr) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    return mat_apply(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    return mat_apply(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver: one block through instance w -------------------
  task automatic run_block(input int w, input logic [127:0] s, input bit keep_ready,
                           output logic [127:0] res, output int lat);
    int n;
    iv[w]  = 1'b1;
    ist[w] = s;
    n = 0;
    while (!ir[w] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    iv[w] = 1'b0;
    lat = 0;
    while (!ov[w] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = ost[w];
    ordy[w] = 1'b1;
    @(posedge clk); #1;
    if (!keep_ready) ordy[w] = 1'b0;
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    iv  = 3'b111;
    for (int w = 0; w < 3; w++) ist[w] = 128'hffff;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    iv  = 3'b000;
    for (int w = 0; w < 3; w++) begin
      total++;
      if (ir[w] !== 1'b1 || ov[w] !== 1'b0 || ost[w] !== 128'h0)
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_state=%h, want 1 0 0",
                 w, ir[w], ov[w], ost[w]);
      else passed++;
    end
  endtask

  task automatic test_single();
    logic [127:0] res;
    int lat;
    run_block(0, V1_IN, 1'b0, res, lat);
    total++;
    if (res !== V1_OUT) $display("FAIL single_data: got %h want %h", res, V1_OUT);
    else passed++;
    total++;
    if (lat !== 4) $display("FAIL single_latency: got %0d want 4", lat);
    else passed++;
    total++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0)
      $display("FAIL single_release: in_ready=%b out_valid=%b want 1 0", ir[0], ov[0]);
    else passed++;
  endtask

  task automatic test_edges();
    logic [127:0] res;
    logic [127:0] v;
    int lat;
    v = 128'hc6c6c6c6_01010101_00000000_ffffffff;
    run_block(0, v, 1'b0, res, lat);
    total++;
    if (res !== v) $display("FAIL identity: got %h want %h", res, v);
    else passed++;
    v = 128'h4d7ebdf8_00000000_11111111_80808080;
    run_block(0, v, 1'b0, res, lat);
    total++;
    if (res[127:96] !== 32'h2d26314c || res !== ref_inv(v))
      $display("FAIL reduction: got %h want %h", res, ref_inv(v));
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [127:0] v, held, exp;
    int n;
    v   = rand128();
    exp = ref_inv(v);
    iv[0] = 1'b1; ist[0] = v;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin @(posedge clk); #1; n++; end
    held = ost[0];
    total++;
    if (held !== exp) $display("FAIL bp_data: got %h want %h", held, exp);
    else passed++;
    iv[0] = 1'b1; ist[0] = ~v;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || ost[0] !== exp)
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out_state=%h want 1 0 %h",
                 i, ov[0], ir[0], ost[0], exp);
      else passed++;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    total++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0)
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", ir[0], ov[0]);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [127:0] res, v;
    int lat;
    iv[0] = 1'b1; ist[0] = rand128();
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || ost[0] !== 128'h0)
      $display("FAIL mid_reset: in_ready=%b out_valid=%b out_state=%h want 1 0 0",
               ir[0], ov[0], ost[0]);
    else passed++;
    v = rand128();
    run_block(0, v, 1'b0, res, lat);
    total++;
    if (res !== ref_inv(v) || lat !== 4)
      $display("FAIL post_reset: got %h lat %0d want %h lat 4", res, lat, ref_inv(v));
    else passed++;
  endtask

  task automatic test_lanes();
    logic [127:0] res;
    int lat;
    for (int w = 1; w < 3; w++) begin
      run_block(w, V1_IN, 1'b0, res, lat);
      total++;
      if (res !== V1_OUT) $display("FAIL lanes%0d_data: got %h want %h", w*2, res, V1_OUT);
      else passed++;
      total++;
      if (lat !== (w == 1 ? 2 : 1))
        $display("FAIL lanes%0d_latency: got %0d want %0d", w*2, lat, (w == 1 ? 2 : 1));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] v, res;
    int lat;
    int bad;
    for (int w = 0; w < 3; w++) begin
      ordy[w] = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        v = rand128();
        run_block(w, v, 1'b1, res, lat);
        if (res !== ref_inv(v)) begin
          if (bad < 4)
            $display("FAIL b2b[%0d][%0d]: in %h got %h want %h", w, i, v, res, ref_inv(v));
          bad++;
        end
      end
      total++;
      if (bad != 0) $display("FAIL b2b_count[%0d]: %0d wrong, want 0", w, bad);
      else passed++;
      ordy[w] = 1'b0;
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] v, res;
    int lat;
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      v = rand128();
      run_block(i % 3, ref_mix(v), 1'b0, res, lat);
      total++;
      if (res !== v) begin
        $display("FAIL round_trip[%0d]: got %h want %h", i, res, v);
        bad++;
      end else passed++;
    end
  endtask

  initial begin
    iv = '0; ordy = '0;
    for (int w = 0; w < 3; w++) ist[w] = '0;
    test_reset();
    test_single();
    test_edges();
    test_backpressure();
    test_mid_reset();
    test_lanes();
    test_back_to_back();
    test_round_trip();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the combinational MixColumns stage. It accepts one 128-bit state over a valid/ready handshake and processes `NUM_LANES` columns per cycle using GF(2^8) multiplies by 0x0e, 0x0b, 0x0d and 0x09. It then presents the result on a held output handshake. It sits between InvShiftRows/InvSubBytes/AddRoundKey in the inverse-cipher round loop.

## Interface
- `NUM_LANES`, default 1: columns transformed per cycle.
  - Legal values are 1, 2 and 4.
  - Any other value is a synthesis-time error.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `in_valid`: input, 1 bit. `in_state` is valid.
- `in_ready`: output, 1 bit. The block can accept a state.
- `in_state`: input, 128 bits. State byte s[r][c] is `in_state[127-8*(4c+r) -: 8]` (FIPS-197 byte order; column c is `in_state[127-32c -: 32]`, row 0 in the MSB).
- `out_valid`: output, 1 bit. `out_state` holds a finished result.
- `out_ready`: input, 1 bit. The consumer accepts the result.
- `out_state`: output, 128 bits. Result, same byte mapping as `in_state`.

## Operation
- FSM states:
  - IDLE → BUSY on `in_valid && in_ready`.
  - BUSY → DONE after the last column group is written.
  - DONE → IDLE on `out_ready`.
- `in_ready` = 1 only in IDLE. `out_valid` = 1 only in DONE.
- On accept:
  - `in_state` is captured into the working register.
  - The column counter `col` is set to 0.
- In BUSY, each cycle transforms columns `col .. col+NUM_LANES-1` in place, then `col += NUM_LANES`.
  - BUSY ends when `col` would reach 4; the counter wraps to 0.
  - Untouched columns keep their values.
- Per column (a0..a3 → b0..b3), with ⊗ meaning GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11b):
  - b0 = 0e⊗a0 ^ 0b⊗a1 ^ 0d⊗a2 ^ 09⊗a3
  - b1 = 09⊗a0 ^ 0e⊗a1 ^ 0b⊗a2 ^ 0d⊗a3
  - b2 = 0d⊗a0 ^ 09⊗a1 ^ 0e⊗a2 ^ 0b⊗a3
  - b3 = 0b⊗a0 ^ 0d⊗a1 ^ 09⊗a2 ^ 0e⊗a3
- xtime(x) = (x<<1)[7:0] ^ (x[7] ? 8'h1b : 8'h00).
  - The conditional reduction is based on the operand's own bit 7.
  - The multiplies are built from xtime chains:
    - 09 = x8 ^ x
    - 0b = x8 ^ x2 ^ x
    - 0d = x8 ^ x4 ^ x
    - 0e = x8 ^ x4 ^ x2
  - All intermediates are 8 bits.
- `out_state` is driven directly from the working register.
  - It is stable for the whole DONE period.
  - In other states its value is don't-care, but it must not be X after reset.
- `in_valid` and `in_state` are ignored outside IDLE. There is no buffering of a second block.

## Timing
- Reset, whenever `rst`=1 at an edge:
  - FSM → IDLE, `col` = 0, working register = 0.
  - Next cycle: `in_ready`=1, `out_valid`=0, `out_state`=0.
  - Reset overrides any handshake in the same cycle.
- Reset mid-BUSY or in DONE aborts the block with no output. A pending result is dropped.
- Accept at edge T. Column groups are written at edges T+1 … T+4/NUM_LANES. `out_valid` rises after edge T+4/NUM_LANES.
  - Latency is 4, 2 or 1 cycles from accept to `out_valid`.
- `out_valid` stays high while `out_ready`=0; the data holds.
- Output handshake at edge D gives IDLE at D+1, with `in_ready`=1 in cycle D+1.
  - Peak throughput is one block per 4/NUM_LANES + 2 cycles.
- `out_ready` asserted early (before DONE) has no effect.

## Test plan
- Single column, NUM_LANES=1: `in_state` = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 → `out_state` = db135345_f20a225c_01010101_d4d4d4d5. `out_valid` rises exactly 4 cycles after accept.
- Identity/edge columns: `in_state` = c6c6c6c6_01010101_00000000_ffffffff → output equals the input. Also `in_state` = 4d7ebdf8_… → 2d26314c in that column, checking the 0x1b reduction path.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `out_valid` stays 1, `out_state` is stable, `in_ready` stays 0, and a new `in_valid` is ignored.
- Reset mid-BUSY after column 1 → next cycle `in_ready`=1, `out_valid`=0. A fresh block then produces a correct result with no residue.
- NUM_LANES=2 and 4 with the first vector → same output, with `out_valid` at 2 and 1 cycles respectively.
- Back-to-back: 100 random states with `out_ready` tied to 1, compared against a software InvMixColumns. Also check MixColumns→inv_mix_columns_seq round-trip equals the original.
